pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch block for the multi-cycle MIPS core. It sits on the consumer side of the decode interface.
- Each fetched instruction is presented to decode. The block then samples that instruction's pc_load/Jump/Branch controls and computes the next PC.
- It fetches the next instruction over a req/ack instruction-memory handshake.
- Supports sequential flow, j/jal, jr, conditional branches and stall (pc_load=0).

---
 rtl/pc_fetch_unit.sv | 101 ++++++++++
 tb/tb_pc_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for the multi-cycle MIPS core.
// Optional: define FETCH_ALIGN_CHECK_EN to add the addr_fault output for misaligned jr / reserved Jump.
//
// state | meaning
// IDLE  | one-cycle settle after reset release
// REQ   | fetch request at pc_out outstanding, waiting for imem_ack
// ISSUE | instr/pc_out valid for decode; waiting for pc_load
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              pc_load,
    input  logic [1:0]        Jump,
    input  logic              Branch,
    input  logic              branch_taken,
    input  logic [31:0]       imm_offset,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              addr_fault,
`endif
    output logic              fetch_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] next_pc;
    logic              load_fire;
    logic              fault;

    // Target selection; Jump=11 falls through to the sequential/branch path.
    always_comb begin
        next_pc = pc_plus4;
        case (Jump)
            2'b01:   next_pc = {pc_plus4[ADDR_W-1:ADDR_W-4], instr[25:0], 2'b00};
            2'b10:   next_pc = jr_target & ~32'h0000_0003;
            default: begin
                if (Branch && branch_taken)
                    next_pc = pc_plus4 + (imm_offset << 2);
            end
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign fault      = (Jump == 2'b11) || ((Jump == 2'b10) && (jr_target[1:0] != 2'b00));
    assign addr_fault = load_fire && fault;
`else
    assign fault = 1'b0;
`endif

    assign load_fire = (state == ISSUE) && pc_load;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (imem_ack) state_nxt = ISSUE;
            ISSUE:   if (pc_load)  state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            pc_out   <= RESET_PC;
            pc_plus4 <= RESET_PC + 32'd4;
            instr    <= 32'h0;
        end else begin
            state <= state_nxt;
            if ((state == REQ) && imem_ack)
                instr <= imem_rdata;
            // A faulting load refetches the current pc instead of redirecting.
            if (load_fire && !fault) begin
                pc_out   <= next_pc;
                pc_plus4 <= next_pc + 32'd4;
            end
        end
    end

    // The fetch address always tracks pc_out, so it is stable for the whole REQ phase.
    assign imem_addr   = pc_out;
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == ISSUE);
    assign fetch_busy  = (state != ISSUE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (default build) with hand-computed PC sequences.
module tb_pc_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        pc_load;
    logic [1:0]  Jump;
    logic        Branch;
    logic        branch_taken;
    logic [31:0] imm_offset;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_busy;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .pc_load      (pc_load),
        .Jump         (Jump),
        .Branch       (Branch),
        .branch_taken (branch_taken),
        .imm_offset   (imm_offset),
        .jr_target    (jr_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .fetch_busy   (fetch_busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    pc_out,      32'h0);
        chk({tag, "_pc4"},   pc_plus4,    32'h4);
        chk({tag, "_instr"}, instr,       32'h0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_req"},   {31'b0, imem_req},    32'h0);
        chk({tag, "_addr"},  imem_addr,   32'h0);
        chk({tag, "_busy"},  {31'b0, fetch_busy},  32'h1);
    endtask

    // Wait for the request, insert wait states, then ack with word.
    task automatic do_fetch(input int delay, input logic [31:0] word, input logic [31:0] exp_addr);
        int guard = 0;
        while (!imem_req && guard < 8) begin
            @(negedge Clock);
            guard++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'h1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            @(negedge Clock);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge Clock);
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        chk("issue_valid", {31'b0, instr_valid}, 32'h1);
        chk("issue_instr", instr, word);
        chk("issue_pc", pc_out, exp_addr);
        chk("issue_pc4", pc_plus4, exp_addr + 32'd4);
        chk("issue_req", {31'b0, imem_req}, 32'h0);
    endtask

    // Apply one load cycle of decode controls while in ISSUE.
    task automatic issue(input logic [1:0] j, input logic br, input logic tk,
                         input logic [31:0] imm, input logic [31:0] jrt);
        pc_load      = 1'b1;
        Jump         = j;
        Branch       = br;
        branch_taken = tk;
        imm_offset   = imm;
        jr_target    = jrt;
        @(negedge Clock);
        pc_load      = 1'b0;
        Jump         = 2'b00;
        Branch       = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; pc_load = 1'b0; Jump = 2'b00; Branch = 1'b0; branch_taken = 1'b0;
        imm_offset = 32'h0; jr_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        @(negedge Clock);
        chk_reset_vals("rst");
        @(negedge Clock);
        Reset = 1'b1;

        // Sequential flow from reset: 0, 4, 8, C, 10
        do_fetch(0, 32'h2001_0001, 32'h0);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 32'h2001_0002, 32'h4);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 32'h2001_0003, 32'h8);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 32'h2001_0004, 32'hC);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 32'h2001_0005, 32'h10);

        // Stall with a stray ack that must be ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("stall_instr", instr, 32'h2001_0005);
            chk("stall_pc", pc_out, 32'h10);
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
        end
        imem_ack = 1'b0;
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 32'h1000_0003, 32'h14);

        // Branch taken backwards from 0x20, then not taken
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_0020);
        do_fetch(0, 32'h1000_FFFD, 32'h20);
        issue(2'b00, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0);
        do_fetch(0, 32'h0, 32'h18);
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_0020);
        do_fetch(0, 32'h1000_FFFD, 32'h20);
        issue(2'b00, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0);
        do_fetch(0, 32'h0, 32'h24);

        // j absolute within the 256MB region; jr overrides a taken branch
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'h1000_0040);
        do_fetch(0, 32'h0800_0100, 32'h1000_0040);
        issue(2'b01, 1'b1, 1'b1, 32'h0000_0010, 32'h0);
        do_fetch(0, 32'h0000_0000, 32'h1000_0400);
        issue(2'b10, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0200);
        do_fetch(0, 32'h0000_0000, 32'h200);

        // Reserved Jump behaves as none; jr low bits cleared
        issue(2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 32'h0000_0000, 32'h204);
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'h0000_0303);
        do_fetch(4, 32'h1234_5678, 32'h300);

        // Wrap at the top of the address space
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        do_fetch(0, 32'h0000_0000, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(1, 32'h2001_0007, 32'h0);

        // Async reset mid-REQ with ack pending
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("pre_rst_req", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        #2;
        Reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge Clock);
        chk_reset_vals("rst_hold");
        imem_ack = 1'b0;
        Reset = 1'b1;
        do_fetch(0, 32'h2001_0009, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
